smart_cargo_uc: RTL and testbench
=================================

Name: smart_cargo_uc

Overview:
- Control unit (Moore FSM) that sequences the smart-cargo elevator datapath.
- Accepts each new origin/destination request and inserts both stops into the stop queue: merged as a ride-along ("carona"), appended at the tail, or dropped as a duplicate.
- Drives car movement one floor per timer period and runs the stop sequence: unload, load, pop, door dwell.
- Sits beside the datapath. Consumes its status flags and drives every datapath enable/select.

Parameters:
- DEPTH, 16, stop-queue entries; the queue scan aborts after DEPTH-1 address increments.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; returns FSM to ESPERA
- bordaNovoDestino  in  1  one-cycle pulse: new request latched
- chegouDestino  in  1  head stop == current floor
- sobe  in  1  head stop > current floor
- temDestino  in  1  queue head non-empty
- fimT  in  1  timer period elapsed
- ramSecDifZero  in  1  scanned queue entry non-empty
- carona_origem, carona_destino  in  1 each  insertion point found for origin / destination
- andarRepetidoOrigem, andarRepetidoDestino  in  1 each  stop already queued
- bordaSensorAtivo  in  1  door-sensor edge (obstruction)
- enableRegDestino, enableRAM, enableTopRAM, fit, shift  out  1 each
- select1, select2, select3  out  1 each
- zeraT, contaT  out  1 each
- enableAndarAtual  out  1
- zeraAddrSecundario, contaAddrSecundario  out  1 each
- coloca_objetos, tira_objetos  out  1 each
- erro_fila  out  1  one-cycle pulse: queue full, request dropped
- db_estado  out  4  current state code

Behaviour:
- Clock and reset: single clock `clock`. Reset is synchronous and active-high on `reset`. It forces state ESPERA (0), clears pend, scan and fit_r, and drives all outputs 0.
- Reset mid-operation: abandons the operation with no partial RAM write after the reset edge.
- Outputs: Moore, decoded from the state register (plus fit_r). An output is valid in the cycle its state is active. Any output not listed for a state is 0.
- pend flag: set by bordaNovoDestino in any state other than ESPERA. Cleared on entering REG_PEDIDO.
- scan: internal counter, width clog2(DEPTH). Zeroed alongside zeraAddrSecundario; incremented alongside contaAddrSecundario.
- State 0, ESPERA:
  - bordaNovoDestino or pend → 1.
  - else temDestino → 8.
  - else stay.
- State 1, REG_PEDIDO: enableRegDestino = 1 → 2.
- State 2, ZERA_O: zeraAddrSecundario = 1, scan = 0 → 3.
- State 3, BUSCA_O: select1 = 1, select3 = (scan == 0). Priority order:
  - andarRepetidoOrigem → 5.
  - carona_origem → fit_r = 1, go to 4.
  - !ramSecDifZero → fit_r = 0, go to 4 (append).
  - scan == DEPTH-1 → 15.
  - else contaAddrSecundario = 1, stay.
- State 4, GRAVA_O: enableRAM = 1, fit = fit_r → 5.
- State 5, ZERA_D: zeraAddrSecundario = 1, scan = 0 → 6.
- State 6, BUSCA_D: same as state 3 with select1 = 0, inputs andarRepetidoDestino / carona_destino, targets 0 (duplicate) and 7 (write).
- State 7, GRAVA_D: enableRAM = 1, fit = fit_r → 0.
- State 8, PREP_MOVE: zeraT = 1 → 9.
- State 9, MOVE: contaT = 1.
  - chegouDestino → 11 (has priority over fimT).
  - else fimT → 10.
  - else stay.
- State 10, ANDA: enableAndarAtual = 1, select2 = sobe (1 = up) → 8.
- State 11, DESEMBARQUE: tira_objetos = 1 → 12.
- State 12, EMBARQUE: coloca_objetos = 1 → 13.
- State 13, REMOVE: shift = 1 → 14.
- State 14, PORTA: contaT = 1.
  - bordaSensorAtivo → zeraT = 1 instead of contaT, stay (dwell restarts).
  - else fimT → 0.
- State 15, CHEIO: erro_fila = 1 → 0. The request is discarded. If origin was already written in state 4, it stays queued.
- A request never interrupts motion. It is serviced at the next return to ESPERA, ahead of further movement.
- enableTopRAM is reserved and tied 0 in every state.

Test Plan:
- Reset held 2 cycles mid-MOVE → db_estado = 0, all outputs 0, no RAM write after the reset edge; pend cleared.
- Empty queue, bordaNovoDestino pulse, ramSecDifZero = 0 → states 1, 2, 3, 4 (enableRAM = 1, fit = 0), 5, 6, 7 (enableRAM = 1), 0. Each state lasts exactly 1 cycle.
- Origin scan: ramSecDifZero = 1, carona_origem asserted on the 3rd BUSCA_O cycle → exactly 2 contaAddrSecundario pulses; select3 = 1 only in the first BUSCA_O cycle; GRAVA_O with fit = 1.
- temDestino = 1, sobe = 1, fimT pulsed 3 times, then chegouDestino → 3 single-cycle enableAndarAtual pulses each with select2 = 1, then 11, 12, 13 (shift = 1).
- PORTA with bordaSensorAtivo pulse before fimT → zeraT = 1 for 1 cycle, FSM stays in 14; the next fimT → 0.
- All entries non-empty, no hits → DEPTH-1 increments, then erro_fila = 1 for one cycle, db_estado returns to 0. bordaNovoDestino during MOVE → serviced as REG_PEDIDO directly after PORTA → ESPERA.

Source files
------------

// File: rtl/smart_cargo_uc.sv
// Smart-cargo elevator control unit: request insertion into the stop
// queue, car movement and the unload/load/pop/door stop sequence.
module smart_cargo_uc #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bordaNovoDestino,
  input  logic       chegouDestino,
  input  logic       sobe,
  input  logic       temDestino,
  input  logic       fimT,
  input  logic       ramSecDifZero,
  input  logic       carona_origem,
  input  logic       carona_destino,
  input  logic       andarRepetidoOrigem,
  input  logic       andarRepetidoDestino,
  input  logic       bordaSensorAtivo,
  output logic       enableRegDestino,
  output logic       enableRAM,
  output logic       enableTopRAM,
  output logic       fit,
  output logic       shift,
  output logic       select1,
  output logic       select2,
  output logic       select3,
  output logic       zeraT,
  output logic       contaT,
  output logic       enableAndarAtual,
  output logic       zeraAddrSecundario,
  output logic       contaAddrSecundario,
  output logic       coloca_objetos,
  output logic       tira_objetos,
  output logic       erro_fila,
  output logic [3:0] db_estado
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [3:0] {
    ESPERA      = 4'd0,
    REG_PEDIDO  = 4'd1,
    ZERA_O      = 4'd2,
    BUSCA_O     = 4'd3,
    GRAVA_O     = 4'd4,
    ZERA_D      = 4'd5,
    BUSCA_D     = 4'd6,
    GRAVA_D     = 4'd7,
    PREP_MOVE   = 4'd8,
    MOVE        = 4'd9,
    ANDA        = 4'd10,
    DESEMBARQUE = 4'd11,
    EMBARQUE    = 4'd12,
    REMOVE      = 4'd13,
    PORTA       = 4'd14,
    CHEIO       = 4'd15
  } state_t;

  state_t        state;
  logic          pend;
  logic          fitR;
  logic [AW-1:0] scan;

  logic   busca;
  logic   rep;
  logic   car;
  logic   scanStep;
  state_t tgtDup;
  state_t tgtWr;

  // Origin and destination scans share one datapath; only the hit
  // flags and the exit states differ.
  always_comb begin
    busca  = (state == BUSCA_O) || (state == BUSCA_D);
    rep    = andarRepetidoOrigem;
    car    = carona_origem;
    tgtDup = ZERA_D;
    tgtWr  = GRAVA_O;
    if (state == BUSCA_D) begin
      rep    = andarRepetidoDestino;
      car    = carona_destino;
      tgtDup = ESPERA;
      tgtWr  = GRAVA_D;
    end
    scanStep = busca && !rep && !car &&
               ramSecDifZero && (scan != LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ESPERA;
      pend  <= 1'b0;
      scan  <= '0;
      fitR  <= 1'b0;
    end else begin
      if (bordaNovoDestino && state != ESPERA)
        pend <= 1'b1;
      unique case (state)
        ESPERA: begin
          if (bordaNovoDestino || pend) begin
            state <= REG_PEDIDO;
            pend  <= 1'b0;
          end else if (temDestino) begin
            state <= PREP_MOVE;
          end
        end
        REG_PEDIDO: state <= ZERA_O;
        ZERA_O: begin
          scan  <= '0;
          state <= BUSCA_O;
        end
        BUSCA_O, BUSCA_D: begin
          if (rep) begin
            state <= tgtDup;
          end else if (car) begin
            fitR  <= 1'b1;
            state <= tgtWr;
          end else if (!ramSecDifZero) begin
            fitR  <= 1'b0;
            state <= tgtWr;
          end else if (scan == LAST) begin
            state <= CHEIO;
          end else begin
            scan <= scan + 1'b1;
          end
        end
        GRAVA_O: state <= ZERA_D;
        ZERA_D: begin
          scan  <= '0;
          state <= BUSCA_D;
        end
        GRAVA_D:     state <= ESPERA;
        PREP_MOVE:   state <= MOVE;
        MOVE: begin
          if (chegouDestino)
            state <= DESEMBARQUE;
          else if (fimT)
            state <= ANDA;
        end
        ANDA:        state <= PREP_MOVE;
        DESEMBARQUE: state <= EMBARQUE;
        EMBARQUE:    state <= REMOVE;
        REMOVE:      state <= PORTA;
        PORTA: begin
          if (!bordaSensorAtivo && fimT)
            state <= ESPERA;
        end
        CHEIO:       state <= ESPERA;
      endcase
    end
  end

  assign enableTopRAM = 1'b0;
  assign db_estado    = state;

  always_comb begin
    enableRegDestino    = 1'b0;
    enableRAM           = 1'b0;
    fit                 = 1'b0;
    shift               = 1'b0;
    select1             = 1'b0;
    select2             = 1'b0;
    select3             = 1'b0;
    zeraT               = 1'b0;
    contaT              = 1'b0;
    enableAndarAtual    = 1'b0;
    zeraAddrSecundario  = 1'b0;
    contaAddrSecundario = 1'b0;
    coloca_objetos      = 1'b0;
    tira_objetos        = 1'b0;
    erro_fila           = 1'b0;
    unique case (state)
      REG_PEDIDO: enableRegDestino = 1'b1;
      ZERA_O, ZERA_D: zeraAddrSecundario = 1'b1;
      BUSCA_O, BUSCA_D: begin
        select1             = (state == BUSCA_O);
        select3             = (scan == '0);
        contaAddrSecundario = scanStep;
      end
      GRAVA_O, GRAVA_D: begin
        enableRAM = 1'b1;
        fit       = fitR;
      end
      PREP_MOVE: zeraT = 1'b1;
      MOVE:      contaT = 1'b1;
      ANDA: begin
        enableAndarAtual = 1'b1;
        select2          = sobe;
      end
      DESEMBARQUE: tira_objetos = 1'b1;
      EMBARQUE:    coloca_objetos = 1'b1;
      REMOVE:      shift = 1'b1;
      PORTA: begin
        zeraT  = bordaSensorAtivo;
        contaT = !bordaSensorAtivo;
      end
      CHEIO: erro_fila = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_smart_cargo_uc.sv
// Testbench for smart_cargo_uc: per-cycle vectors of inputs and
// expected state/outputs, checked through an expectation queue.
module tb_smart_cargo_uc;

  logic       clock = 1'b0;
  logic       reset;
  logic       bordaNovoDestino, chegouDestino, sobe, temDestino, fimT;
  logic       ramSecDifZero, carona_origem, carona_destino;
  logic       andarRepetidoOrigem, andarRepetidoDestino, bordaSensorAtivo;
  logic       enableRegDestino, enableRAM, enableTopRAM, fit, shift;
  logic       select1, select2, select3, zeraT, contaT, enableAndarAtual;
  logic       zeraAddrSecundario, contaAddrSecundario;
  logic       coloca_objetos, tira_objetos, erro_fila;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  smart_cargo_uc #(.DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .bordaNovoDestino(bordaNovoDestino), .chegouDestino(chegouDestino),
    .sobe(sobe), .temDestino(temDestino), .fimT(fimT),
    .ramSecDifZero(ramSecDifZero),
    .carona_origem(carona_origem), .carona_destino(carona_destino),
    .andarRepetidoOrigem(andarRepetidoOrigem),
    .andarRepetidoDestino(andarRepetidoDestino),
    .bordaSensorAtivo(bordaSensorAtivo),
    .enableRegDestino(enableRegDestino), .enableRAM(enableRAM),
    .enableTopRAM(enableTopRAM), .fit(fit), .shift(shift),
    .select1(select1), .select2(select2), .select3(select3),
    .zeraT(zeraT), .contaT(contaT), .enableAndarAtual(enableAndarAtual),
    .zeraAddrSecundario(zeraAddrSecundario),
    .contaAddrSecundario(contaAddrSecundario),
    .coloca_objetos(coloca_objetos), .tira_objetos(tira_objetos),
    .erro_fila(erro_fila), .db_estado(db_estado)
  );

  localparam logic [11:0] I_RST = 12'h800, I_ND = 12'h400;
  localparam logic [11:0] I_CHG = 12'h200, I_UP = 12'h100;
  localparam logic [11:0] I_TEM = 12'h080, I_FIM = 12'h040;
  localparam logic [11:0] I_DZ = 12'h020, I_CO = 12'h010;
  localparam logic [11:0] I_CD = 12'h008, I_RO = 12'h004;
  localparam logic [11:0] I_RD = 12'h002, I_SEN = 12'h001;

  localparam logic [15:0] O_REG = 16'h8000, O_RAM = 16'h4000;
  localparam logic [15:0] O_FIT = 16'h1000, O_SHF = 16'h0800;
  localparam logic [15:0] O_S1 = 16'h0400, O_S2 = 16'h0200;
  localparam logic [15:0] O_S3 = 16'h0100, O_ZT = 16'h0080;
  localparam logic [15:0] O_CT = 16'h0040, O_AND = 16'h0020;
  localparam logic [15:0] O_ZA = 16'h0010, O_CA = 16'h0008;
  localparam logic [15:0] O_COL = 16'h0004, O_TIR = 16'h0002;
  localparam logic [15:0] O_ERR = 16'h0001;

  typedef struct {
    logic [11:0] in;
    logic [3:0]  st;
    logic [15:0] out;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] expQ[$];
  int          tests = 0;
  int          fails = 0;
  int          caCount;

  wire [15:0] outv = {enableRegDestino, enableRAM, enableTopRAM, fit,
                      shift, select1, select2, select3, zeraT, contaT,
                      enableAndarAtual, zeraAddrSecundario,
                      contaAddrSecundario, coloca_objetos, tira_objetos,
                      erro_fila};

  task automatic add(input logic [11:0] i, input logic [3:0] s,
                     input logic [15:0] o);
    vec_t v;
    v.in = i; v.st = s; v.out = o;
    vecs.push_back(v);
  endtask

  task automatic check(input string name);
    logic [19:0] e;
    e = expQ.pop_front();
    tests++;
    if ({db_estado, outv} !== e) begin
      fails++;
      $display("FAIL %s: got st=%0d out=%h, want st=%0d out=%h",
               name, db_estado, outv, e[19:16], e[15:0]);
    end
  endtask

  // Drive one cycle's inputs, queue the expectation, compare mid-cycle.
  task automatic step(input logic [11:0] i, input logic [3:0] s,
                      input logic [15:0] o, input string name);
    {reset, bordaNovoDestino, chegouDestino, sobe, temDestino, fimT,
     ramSecDifZero, carona_origem, carona_destino, andarRepetidoOrigem,
     andarRepetidoDestino, bordaSensorAtivo} = i;
    expQ.push_back({s, o});
    @(negedge clock);
    if (contaAddrSecundario) caCount++;
    check(name);
    @(posedge clock);
    #1;
  endtask

  initial begin
    {reset, bordaNovoDestino, chegouDestino, sobe, temDestino, fimT,
     ramSecDifZero, carona_origem, carona_destino, andarRepetidoOrigem,
     andarRepetidoDestino, bordaSensorAtivo} = I_RST;
    @(posedge clock);
    #1;
    step(I_RST, 0, 0, "reset");
    step(0, 0, 0, "idle");

    // Request into an empty queue: append both stops.
    add(I_ND, 0, 0);
    add(0, 1, O_REG);
    add(0, 2, O_ZA);
    add(0, 3, O_S1 | O_S3);
    add(0, 4, O_RAM);
    add(0, 5, O_ZA);
    add(0, 6, O_S3);
    add(0, 7, O_RAM);
    add(0, 0, 0);
    // Origin ride-along on the third scan entry, duplicate destination.
    add(I_ND, 0, 0);
    add(0, 1, O_REG);
    add(0, 2, O_ZA);
    add(I_DZ, 3, O_S1 | O_S3 | O_CA);
    add(I_DZ, 3, O_S1 | O_CA);
    add(I_DZ | I_CO, 3, O_S1);
    add(0, 4, O_RAM | O_FIT);
    add(0, 5, O_ZA);
    add(I_DZ | I_RD, 6, O_S3);
    add(0, 0, 0);
    // Duplicate origin skips straight to the destination scan.
    add(I_ND, 0, 0);
    add(0, 1, O_REG);
    add(0, 2, O_ZA);
    add(I_DZ | I_RO, 3, O_S1 | O_S3);
    add(0, 5, O_ZA);
    add(I_DZ | I_CD, 6, O_S3);
    add(0, 7, O_RAM | O_FIT);
    add(0, 0, 0);
    // Three floors up, arrival, stop sequence, door obstruction.
    add(I_TEM | I_UP, 0, 0);
    add(I_TEM | I_UP, 8, O_ZT);
    add(I_TEM | I_UP, 9, O_CT);
    for (int k = 0; k < 3; k++) begin
      add(I_TEM | I_UP | I_FIM, 9, O_CT);
      add(I_TEM | I_UP, 10, O_AND | O_S2);
      add(I_TEM | I_UP, 8, O_ZT);
    end
    add(I_TEM | I_CHG | I_FIM, 9, O_CT);
    add(I_TEM, 11, O_TIR);
    add(I_TEM, 12, O_COL);
    add(I_TEM, 13, O_SHF);
    add(I_TEM, 14, O_CT);
    add(I_TEM | I_SEN | I_FIM, 14, O_ZT);
    add(I_TEM, 14, O_CT);
    add(I_TEM | I_FIM, 14, O_CT);
    add(0, 0, 0);
    // One floor down.
    add(I_TEM, 0, 0);
    add(I_TEM, 8, O_ZT);
    add(I_TEM | I_FIM, 9, O_CT);
    add(I_TEM, 10, O_AND);
    add(0, 8, O_ZT);

    for (int n = 0; n < vecs.size(); n++)
      step(vecs[n].in, vecs[n].st, vecs[n].out, $sformatf("vec%0d", n));
    step(I_RST, 9, O_CT, "rst_in_move");
    step(0, 0, 0, "rst_after");

    // Full queue: DEPTH-1 increments, then the error pulse.
    caCount = 0;
    step(I_ND, 0, 0, "full_idle");
    step(0, 1, O_REG, "full_reg");
    step(0, 2, O_ZA, "full_zera");
    for (int k = 0; k < 16; k++)
      step(I_DZ, 3,
           O_S1 | (k == 0 ? O_S3 : 16'h0) | (k < 15 ? O_CA : 16'h0),
           $sformatf("full_scan%0d", k));
    step(0, 15, O_ERR, "full_cheio");
    step(0, 0, 0, "full_back");
    tests++;
    if (caCount != 15) begin
      fails++;
      $display("FAIL full_incs: got %0d, want 15", caCount);
    end

    // Request during motion is served right after the door closes.
    step(I_TEM, 0, 0, "pend_idle");
    step(I_TEM, 8, O_ZT, "pend_prep");
    step(I_TEM | I_ND, 9, O_CT, "pend_pulse");
    step(I_TEM | I_CHG, 9, O_CT, "pend_arrive");
    step(I_TEM, 11, O_TIR, "pend_unload");
    step(I_TEM, 12, O_COL, "pend_load");
    step(I_TEM, 13, O_SHF, "pend_pop");
    step(I_TEM | I_FIM, 14, O_CT, "pend_door");
    step(I_TEM, 0, 0, "pend_espera");
    step(I_TEM, 1, O_REG, "pend_reg");
    step(0, 2, O_ZA, "pend_zera");
    step(0, 3, O_S1 | O_S3, "pend_busca");
    step(0, 4, O_RAM, "pend_grava");
    step(0, 5, O_ZA, "pend_zd");
    step(0, 6, O_S3, "pend_bd");
    step(0, 7, O_RAM, "pend_gd");
    step(0, 0, 0, "pend_done");

    // Reset held two cycles mid-MOVE clears a pending request.
    step(I_TEM, 0, 0, "rm_idle");
    step(I_TEM, 8, O_ZT, "rm_prep");
    step(I_TEM | I_ND, 9, O_CT, "rm_pend");
    step(I_RST | I_TEM, 9, O_CT, "rm_rst1");
    step(I_RST | I_TEM, 0, 0, "rm_rst2");
    step(0, 0, 0, "rm_after1");
    step(0, 0, 0, "rm_after2");

    // Reset in GRAVA_O: no write once the edge is taken.
    step(I_ND, 0, 0, "rw_idle");
    step(0, 1, O_REG, "rw_reg");
    step(0, 2, O_ZA, "rw_zera");
    step(0, 3, O_S1 | O_S3, "rw_busca");
    step(I_RST, 4, O_RAM, "rw_grava");
    step(0, 0, 0, "rw_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
